// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared types and constants for the CAS tape read buffer
package tape_pkg;

   localparam int LINE_BYTES     = 8;
   localparam int WORDS_PER_LINE = 4;
   localparam int OFF_W          = $clog2(LINE_BYTES);
   localparam int WIDX_W         = $clog2(WORDS_PER_LINE);

   // CAS block signature; lines are aligned to its 8-byte grid
   localparam logic [63:0] CAS_SIGNATURE = 64'h1FA6DEBACC137D74;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      FILL,
      PREFETCH
   } tb_state_t;

endpackage

// File: rtl/tape_line.sv
// rtl/tape_line.sv - one 8-byte buffer line: tag, valid bit, word write port, byte read port
module tape_line
   import tape_pkg::*;
#(
   parameter int TAG_W = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              inval,
   input  logic              start,
   input  logic [TAG_W-1:0]  start_tag,
   input  logic              wr_en,
   input  logic [WIDX_W-1:0] wr_word,
   input  logic [15:0]       wr_data,
   input  logic              set_valid,
   input  logic [OFF_W-1:0]  rd_off,
   output logic [7:0]        rd_byte,
   output logic [TAG_W-1:0]  tag,
   output logic              valid
);

   logic [LINE_BYTES*8-1:0] data;

   // Tag is claimed when a fill starts; the line stays invalid until the last word lands
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag   <= '0;
         valid <= 1'b0;
      end else begin
         if (start) begin
            tag <= start_tag;
         end
         if (inval || start) begin
            valid <= 1'b0;
         end else if (set_valid) begin
            valid <= 1'b1;
         end
      end
   end

   // Little-endian word store: the low byte of each word sits at the lower byte offset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
      end else if (wr_en) begin
         data[{wr_word, 4'b0000} +: 16] <= wr_data;
      end
   end

   assign rd_byte = data[{rd_off, 3'b000} +: 8];

endmodule

// File: rtl/tape_buffer.sv
// rtl/tape_buffer.sv - two-line byte read buffer between CAS player and SDRAM (option: TAPE_BUFFER_PREFETCH_EN)
module tape_buffer
   import tape_pkg::*;
#(
   parameter int ADDR_W = 27
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] ram_a,
   input  logic              ram_rd,
   output logic [7:0]        ram_di,
   output logic              buff_mem_ready,
   input  logic              img_mounted,
   input  logic [ADDR_W-1:0] img_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [15:0]       mem_dout,
   output logic              eof
);

   localparam int TAG_W = ADDR_W - OFF_W;

   tb_state_t          state, state_n;

   logic               ram_rd_q;
   logic [ADDR_W-1:0]  req_addr;
   logic [ADDR_W-1:0]  img_size_q;
   logic [TAG_W-1:0]   req_tag;
   logic [OFF_W-1:0]   req_off;

   logic [TAG_W-1:0]   line_tag   [2];
   logic [7:0]         line_byte  [2];
   logic [1:0]         line_valid;

   logic               last_line;
   logic               fill_line;
   logic [TAG_W-1:0]   fill_tag;
   logic [WIDX_W-1:0]  word_idx;
   logic               fill_abort;
   logic               pend;

   logic               accept;
   logic               hit_a, hit_b, hit, oor, resolve;
   logic [7:0]         hit_byte;
   logic               fill_busy, abort_any, last_word;
   logic               word_ack, fill_end, fill_ok, issue;
   logic               start_fill;
   logic [TAG_W-1:0]   start_tag;
   logic [TAG_W-1:0]   pf_tag;
   logic               pf_go;

   assign accept   = ram_rd && !ram_rd_q && buff_mem_ready;
   assign req_tag  = req_addr[ADDR_W-1:OFF_W];
   assign req_off  = req_addr[OFF_W-1:0];

   // A mount in the lookup cycle already counts as invalidation
   assign hit_a    = line_valid[0] && (line_tag[0] == req_tag) && !img_mounted;
   assign hit_b    = line_valid[1] && (line_tag[1] == req_tag) && !img_mounted;
   assign hit      = hit_a || hit_b;
   assign hit_byte = hit_b ? line_byte[1] : line_byte[0];
   assign oor      = (req_addr >= img_size_q);
   assign resolve  = (state == LOOKUP) && (oor || hit);

   assign fill_busy = (state == FILL) || (state == PREFETCH);
   assign abort_any = fill_abort || img_mounted;
   assign last_word = (word_idx == WIDX_W'(WORDS_PER_LINE - 1));
   assign word_ack  = fill_busy && mem_req && mem_ack;
   assign fill_ok   = word_ack && last_word && !abort_any;
   assign issue     = fill_busy && !mem_req && !abort_any;

   // An aborted fill ends as soon as no word handshake is outstanding
   assign fill_end  = fill_busy && (abort_any ? (!mem_req || mem_ack)
                                              : (mem_req && mem_ack && last_word));

`ifdef TAPE_BUFFER_PREFETCH_EN
   logic [TAG_W-1:0] last_tag;
   logic             have_last;
   logic             pf_present;

   assign pf_tag     = last_tag + {{(TAG_W-1){1'b0}}, 1'b1};
   assign pf_present = (line_valid[0] && (line_tag[0] == pf_tag)) ||
                       (line_valid[1] && (line_tag[1] == pf_tag));
   assign pf_go      = have_last && !pf_present && !img_mounted &&
                       ({pf_tag, {OFF_W{1'b0}}} < img_size_q);

   // Remember the most recently served line so the following one can be fetched early
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_tag  <= '0;
         have_last <= 1'b0;
      end else if (img_mounted) begin
         have_last <= 1'b0;
      end else if (resolve && !oor) begin
         last_tag  <= req_tag;
         have_last <= 1'b1;
      end
   end
`else
   assign pf_tag = '0;
   assign pf_go  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and fill start decision
   always_comb begin
      state_n    = state;
      start_fill = 1'b0;
      start_tag  = req_tag;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = LOOKUP;
            end else if (pf_go) begin
               state_n    = PREFETCH;
               start_fill = 1'b1;
               start_tag  = pf_tag;
            end
         end
         LOOKUP: begin
            if (oor || hit) begin
               state_n = IDLE;
            end else begin
               state_n    = FILL;
               start_fill = 1'b1;
            end
         end
         FILL: begin
            if (fill_end) begin
               state_n = LOOKUP;
            end
         end
         PREFETCH: begin
            if (fill_end) begin
               state_n = (pend || accept) ? LOOKUP : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Player side: request capture, ready handshake, returned byte and eof flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_rd_q       <= 1'b0;
         req_addr       <= '0;
         img_size_q     <= '0;
         buff_mem_ready <= 1'b1;
         ram_di         <= 8'h00;
         eof            <= 1'b0;
         last_line      <= 1'b0;
      end else begin
         ram_rd_q <= ram_rd;
         if (img_mounted) begin
            img_size_q <= img_size;
         end
         if (accept) begin
            req_addr       <= ram_a;
            buff_mem_ready <= 1'b0;
         end
         if (resolve) begin
            buff_mem_ready <= 1'b1;
            ram_di         <= oor ? 8'h00 : hit_byte;
         end
         if (img_mounted) begin
            eof <= 1'b0;
         end else if (resolve) begin
            eof <= oor;
         end
         if (resolve && !oor) begin
            last_line <= hit_b;
         end
      end
   end

   // Memory side: one word outstanding at a time, address held until acknowledged
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_line  <= 1'b0;
         fill_tag   <= '0;
         word_idx   <= '0;
         fill_abort <= 1'b0;
         pend       <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         if (start_fill) begin
            fill_line  <= ~last_line;
            fill_tag   <= start_tag;
            word_idx   <= '0;
            fill_abort <= 1'b0;
         end else begin
            if (fill_busy && img_mounted) begin
               fill_abort <= 1'b1;
            end
            if (word_ack) begin
               word_idx <= word_idx + WIDX_W'(1);
            end
         end
         if (state == PREFETCH) begin
            if (fill_end) begin
               pend <= 1'b0;
            end else if (accept) begin
               pend <= 1'b1;
            end
         end
         if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= {fill_tag, word_idx, 1'b0};
         end else if (word_ack) begin
            mem_req <= 1'b0;
         end
      end
   end

   tape_line #(.TAG_W(TAG_W)) u_line_a (
      .clk       (clk),
      .reset_n   (reset_n),
      .inval     (img_mounted),
      .start     (start_fill && last_line),
      .start_tag (start_tag),
      .wr_en     (word_ack && !fill_line),
      .wr_word   (word_idx),
      .wr_data   (mem_dout),
      .set_valid (fill_ok && !fill_line),
      .rd_off    (req_off),
      .rd_byte   (line_byte[0]),
      .tag       (line_tag[0]),
      .valid     (line_valid[0])
   );

   tape_line #(.TAG_W(TAG_W)) u_line_b (
      .clk       (clk),
      .reset_n   (reset_n),
      .inval     (img_mounted),
      .start     (start_fill && !last_line),
      .start_tag (start_tag),
      .wr_en     (word_ack && fill_line),
      .wr_word   (word_idx),
      .wr_data   (mem_dout),
      .set_valid (fill_ok && fill_line),
      .rd_off    (req_off),
      .rd_byte   (line_byte[1]),
      .tag       (line_tag[1]),
      .valid     (line_valid[1])
   );

endmodule

// File: tb/tb_tape_buffer.sv
// tb/tb_tape_buffer.sv - directed self-checking bench for tape_buffer (option: TAPE_BUFFER_PREFETCH_EN)
module tb_tape_buffer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [26:0] ram_a;
   logic        ram_rd;
   logic [7:0]  ram_di;
   logic        buff_mem_ready;
   logic        img_mounted;
   logic [26:0] img_size;
   logic [26:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [15:0] mem_dout;
   logic        eof;

   int checks   = 0;
   int errors   = 0;
   int stab_err = 0;
   int dly_mode = 0;
   int dly_fixed = 0;
   logic [26:0] mem_log[$];

   always #5 clk = ~clk;

   tape_buffer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ram_a          (ram_a),
      .ram_rd         (ram_rd),
      .ram_di         (ram_di),
      .buff_mem_ready (buff_mem_ready),
      .img_mounted    (img_mounted),
      .img_size       (img_size),
      .mem_addr       (mem_addr),
      .mem_req        (mem_req),
      .mem_ack        (mem_ack),
      .mem_dout       (mem_dout),
      .eof            (eof)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // SDRAM model: byte at address a holds a[7:0]
   initial begin
      logic [26:0] a;
      logic [7:0]  lo;
      int          d;
      mem_ack  = 1'b0;
      mem_dout = '0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (reset_n === 1'b1 && mem_req === 1'b1) begin
            a = mem_addr;
            mem_log.push_back(a);
            if (dly_mode == 0) d = dly_fixed;
            else begin
               case ($urandom_range(0, 2))
                  0:       d = 0;
                  1:       d = 1;
                  default: d = 20;
               endcase
            end
            repeat (d) begin
               @(posedge clk); #1;
               if (mem_addr !== a || mem_req !== 1'b1) stab_err++;
            end
            lo       = a[7:0];
            mem_dout = {lo + 8'd1, lo};
            mem_ack  = 1'b1;
         end
      end
   end

   task automatic wait_ready(output int lat);
      lat = 0;
      while (buff_mem_ready !== 1'b1 && lat < 3000) begin
         @(posedge clk); #2;
         lat++;
      end
      chk("ready_timeout", (lat < 3000), 1);
   endtask

   task automatic do_read(input logic [26:0] a, output logic [7:0] d, output int lat);
      @(posedge clk); #2;
      ram_a  = a;
      ram_rd = 1'b1;
      @(posedge clk); #2;
      ram_rd = 1'b0;
      ram_a  = '1;
      wait_ready(lat);
      d = ram_di;
   endtask

   task automatic mount(input logic [26:0] s);
      @(posedge clk); #2;
      img_size    = s;
      img_mounted = 1'b1;
      @(posedge clk); #2;
      img_mounted = 1'b0;
   endtask

   task automatic chk_fill(input string name, input int base, input logic [26:0] line);
      chk({name, "_nreq"}, mem_log.size() - base, 4);
      if (mem_log.size() - base == 4) begin
         for (int i = 0; i < 4; i++) chk({name, "_addr"}, mem_log[base + i], line + 27'(2 * i));
      end
   endtask

   typedef struct {
      logic [26:0] addr;
      logic [7:0]  data;
      logic        eof;
      logic        miss;
   } vec_t;

   vec_t vecs[17];

   initial begin
      logic [7:0] d;
      int         lat;
      int         base;
      int         n;
      int         rdy_drop;

      reset_n     = 1'b0;
      ram_a       = '0;
      ram_rd      = 1'b0;
      img_mounted = 1'b0;
      img_size    = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_ready",    buff_mem_ready, 1);
      chk("rst_ram_di",   ram_di, 0);
      chk("rst_mem_req",  mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_eof",      eof, 0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("post_rst_ready", buff_mem_ready, 1);

`ifndef TAPE_BUFFER_PREFETCH_EN
      vecs[0]  = '{27'd0,   8'h00, 1'b0, 1'b1};
      vecs[1]  = '{27'd1,   8'h01, 1'b0, 1'b0};
      vecs[2]  = '{27'd2,   8'h02, 1'b0, 1'b0};
      vecs[3]  = '{27'd3,   8'h03, 1'b0, 1'b0};
      vecs[4]  = '{27'd4,   8'h04, 1'b0, 1'b0};
      vecs[5]  = '{27'd5,   8'h05, 1'b0, 1'b0};
      vecs[6]  = '{27'd6,   8'h06, 1'b0, 1'b0};
      vecs[7]  = '{27'd7,   8'h07, 1'b0, 1'b0};
      vecs[8]  = '{27'd64,  8'h00, 1'b1, 1'b0};
      vecs[9]  = '{27'd0,   8'h00, 1'b0, 1'b0};
      vecs[10] = '{27'd63,  8'h3F, 1'b0, 1'b1};
      vecs[11] = '{27'd5,   8'h05, 1'b0, 1'b0};
      vecs[12] = '{27'd100, 8'h00, 1'b1, 1'b0};
      vecs[13] = '{27'd13,  8'h0D, 1'b0, 1'b1};
      vecs[14] = '{27'd60,  8'h3C, 1'b0, 1'b1};
      vecs[15] = '{27'd13,  8'h0D, 1'b0, 1'b0};
      vecs[16] = '{27'd2,   8'h02, 1'b0, 1'b1};

      dly_mode  = 0;
      dly_fixed = 0;
      mount(27'd64);
      for (int i = 0; i < 17; i++) begin
         base = mem_log.size();
         do_read(vecs[i].addr, d, lat);
         chk($sformatf("v%0d_data", i), d, vecs[i].data);
         chk($sformatf("v%0d_eof", i), eof, vecs[i].eof);
         if (vecs[i].miss) begin
            chk($sformatf("v%0d_miss_lat", i), (lat >= 6), 1);
            chk_fill($sformatf("v%0d_fill", i), base, vecs[i].addr & ~27'd7);
         end else begin
            chk($sformatf("v%0d_hit_lat", i), lat, 1);
            chk($sformatf("v%0d_nreq", i), mem_log.size() - base, 0);
         end
      end

      do_read(27'd64, d, lat);
      chk("oor_eof_set", eof, 1);
      mount(27'd64);
      chk("mount_clears_eof", eof, 0);

      dly_fixed = 3;
      base = mem_log.size();
      fork
         do_read(27'd20, d, lat);
         begin
            n = 0;
            while (mem_log.size() < base + 2 && n < 500) begin
               @(posedge clk); #2;
               n++;
            end
            chk("mid_fill_seen", (n < 500), 1);
            img_size    = 27'd64;
            img_mounted = 1'b1;
            @(posedge clk); #2;
            img_mounted = 1'b0;
         end
      join
      chk("abort_nreq", mem_log.size() - base, 6);
      if (mem_log.size() - base == 6) begin
         chk("abort_w0", mem_log[base], 27'd16);
         chk("abort_w1", mem_log[base + 1], 27'd18);
         chk_fill("abort_refill", base + 2, 27'd16);
      end
      chk("abort_data", d, 8'h14);
      base = mem_log.size();
      do_read(27'd21, d, lat);
      chk("after_abort_hit_lat", lat, 1);
      chk("after_abort_hit_data", d, 8'h15);
      chk("after_abort_nreq", mem_log.size() - base, 0);

      base = mem_log.size();
      @(posedge clk); #2;
      ram_a       = 27'd21;
      ram_rd      = 1'b1;
      img_size    = 27'd64;
      img_mounted = 1'b1;
      @(posedge clk); #2;
      ram_rd      = 1'b0;
      img_mounted = 1'b0;
      wait_ready(lat);
      chk("simul_mount_data", ram_di, 8'h15);
      chk_fill("simul_mount_fill", base, 27'd16);
`else
      dly_mode  = 0;
      dly_fixed = 0;
      mount(27'd64);
      base = mem_log.size();
      do_read(27'd0, d, lat);
      chk("pf_first_data", d, 8'h00);
      if (mem_log.size() - base >= 4) begin
         for (int i = 0; i < 4; i++) chk("pf_first_addr", mem_log[base + i], 27'(2 * i));
      end else begin
         chk("pf_first_nreq", mem_log.size() - base, 4);
      end
      n = 0;
      rdy_drop = 0;
      while (mem_log.size() < base + 8 && n < 200) begin
         @(posedge clk); #2;
         if (buff_mem_ready !== 1'b1) rdy_drop++;
         n++;
      end
      chk("pf_seen", (n < 200), 1);
      chk("pf_ready_held", rdy_drop, 0);
      chk_fill("pf_fill", base + 4, 27'd8);
      do_read(27'd8, d, lat);
      chk("pf_hit_lat", lat, 1);
      chk("pf_hit_data", d, 8'h08);
`endif

      mount(27'd1024);
      dly_mode = 1;
      stab_err = 0;
      for (int a = 0; a < 1024; a++) begin
         logic [26:0] aa;
         aa = 27'(a);
         do_read(aa, d, lat);
         chk($sformatf("seq_%0d", a), d, aa[7:0]);
      end
      chk("seq_eof", eof, 0);
      chk("mem_addr_stable", stab_err, 0);
      do_read(27'd1024, d, lat);
      chk("seq_end_eof", eof, 1);
      chk("seq_end_data", d, 8'h00);

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
